hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Register-file scoreboard and issue controller sitting between the decode stage and execute. Tracks which architectural registers have a write in flight and holds each decoded instruction until its source and destination registers are free and execute is ready. Drains pending writes from a configurable number of writeback ports, with same-cycle bypass of clears. Owns the decode-stage stall signal and the outstanding-write count.

## Interface
- NumWb, 2: number of independent writeback ports (≥1).
- MaxOutstanding, 4: maximum in-flight register writes (≥1). Counter width is $clog2(MaxOutstanding+1).
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- dec_valid_i  in  1  decode presents an instruction
- dec_rs1_i / dec_rs2_i  in  5  source register addresses
- dec_rs1_use_i / dec_rs2_use_i  in  1  source actually read
- dec_rd_i  in  5  destination address
- dec_rd_we_i  in  1  instruction writes rd
- ex_ready_i  in  1  execute accepts an instruction this cycle
- flush_i  in  1  kill the instruction in decode (branch redirect)
- wb_valid_i  in  NumWb  writeback port p retires a write
- wb_rd_i  in  NumWb×5  writeback destination per port
- issue_o  out  1  instruction handed to execute this cycle
- stall_o  out  1  decode must hold its instruction
- busy_o  out  32  registered busy vector, bit 0 always 0
- outstanding_o  out  counter width  registered in-flight write count
- err_o  out  1  sticky protocol error

## Operation
- State: busy[31:1], outstanding counter, err flag. All zero on reset.
- Effective busy: busy_eff = busy & ~clr, where clr = OR over ports p of onehot(wb_rd_i[p]) when wb_valid_i[p] is set. Same-cycle writeback clears are visible to the hazard check.
- Hazard: (rs1_use & busy_eff[rs1]) | (rs2_use & busy_eff[rs2]) | (rd_we & busy_eff[rd]) (WAW) | (rd_we & rd≠0 & outstanding_after_wb == MaxOutstanding).
- outstanding_after_wb = outstanding − number of valid writeback ports.
- Register x0 is never busy. A write with rd_we and rd=0 neither sets a bit nor counts.
- issue_o = dec_valid_i & ~flush_i & ~hazard & ex_ready_i.
- stall_o = dec_valid_i & ~flush_i & ~issue_o. stall_o is 0 when flushing.
- Next state:
  - busy_next = busy_eff | (issue_o & rd_we & rd≠0 ? onehot(rd) : 0). If a clear and a set target the same register, the set wins.
  - outstanding_next = outstanding_after_wb + (issue counts ? 1 : 0).
- flush_i does not touch busy or outstanding. Writes already issued still retire.
- Error: err is set and stays set until reset if either condition occurs:
  - A valid writeback targets a register that is not busy, or targets x0.
  - Two valid ports name the same register in one cycle.
  - When an error occurs, the clear still applies. The counter saturates at 0 and never underflows.

## Timing
- Hazard check, issue_o and stall_o are combinational from current state plus inputs. There are no registered outputs on the issue path.
- busy_o and outstanding_o update on the clock edge after the issue or writeback.
- Back-to-back dependent instruction:
  - Producer issues in cycle N, so its rd is busy from N+1.
  - The consumer stalls until the cycle its writeback is valid, and issues in that same cycle (bypass).
- Asynchronous reset mid-operation zeroes all state immediately. issue_o falls with it.

## Structure
- nebula package: reg_addr_t (logic [4:0]) and NumRegs = 32. These are shared with decode and the register file.
- Single module, no sub-module. The clear mask and popcount of wb_valid_i are local always_comb blocks.
- Assertions (under `ifndef NDEBUG`):
  - busy_o[0] == 0.
  - popcount(busy) == outstanding.
  - issue_o and stall_o are never both 1.

## Test plan
- Reset, then issue `addi x5` (rd=5, rd_we) → issue_o=1; next cycle busy_o[5]=1 and outstanding_o=1.
- RAW: with x5 busy, present rs1=5 → stall_o=1 for 3 cycles. Drive wb_valid_i[0] with rd=5 in cycle 4 → issue_o=1 in the same cycle; busy_o[5]=0 after.
- Capacity: issue writes to x1–x4 with no writeback → a fifth write to x6 stalls. A non-writing instruction (rd_we=0, sources free) still issues. A writeback on x2 releases x6 the same cycle.
- Simultaneous ports: wb0 retires x1 and wb1 retires x3 while issuing a write to x1 → busy_o shows x1 set, x3 clear; outstanding decreases by 1 net.
- Flush: dec_valid_i=1 with a hazard and flush_i=1 → issue_o=0, stall_o=0, busy_o unchanged.
- Errors and reset:
  - Writeback to free x7 → err_o=1 and stays 1. Writeback to x0 gives the same result.
  - Both ports naming x1 in one cycle → err_o=1.
  - Asserting rst_n_i=0 mid-stall → all outputs 0 immediately.

Source files
------------

// File: rtl/nebula_pkg.sv
// Shared definitions for the integer pipeline: register address type and
// register-file size, used by decode, the register file and the scoreboard.
package nebula_pkg;

  localparam int unsigned NumRegs  = 32;
  localparam int unsigned RegAddrW = 5;

  typedef logic [RegAddrW-1:0] reg_addr_t;

  // One-hot decode of a register address.
  function automatic logic [NumRegs-1:0] reg_onehot(input reg_addr_t addr);
    logic [NumRegs-1:0] oh;
    oh       = '0;
    oh[addr] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Register-file scoreboard and issue controller between decode and execute.
//
// Tracks architectural registers with a write in flight and holds the decoded
// instruction until its sources/destination are free and execute is ready.
// Writeback clears are bypassed into the same-cycle hazard check.
//
// Ports:
//   clk_i, rst_n_i                 clock, asynchronous active-low reset
//   dec_valid_i                    decode presents an instruction
//   dec_rs1_i/dec_rs2_i            source addresses, with *_use_i qualifiers
//   dec_rd_i, dec_rd_we_i          destination address and write enable
//   ex_ready_i                     execute accepts an instruction this cycle
//   flush_i                        kill the instruction in decode
//   wb_valid_i, wb_rd_i            per-port writeback retire (5 bits per port)
//   issue_o, stall_o               handoff to execute / hold decode
//   busy_o                         registered busy vector (bit 0 always 0)
//   outstanding_o                  registered in-flight write count
//   err_o                          sticky protocol error
module hazard_scoreboard
  import nebula_pkg::*;
#(
  parameter int unsigned NumWb          = 2,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      dec_valid_i,
  input  logic [RegAddrW-1:0]       dec_rs1_i,
  input  logic [RegAddrW-1:0]       dec_rs2_i,
  input  logic                      dec_rs1_use_i,
  input  logic                      dec_rs2_use_i,
  input  logic [RegAddrW-1:0]       dec_rd_i,
  input  logic                      dec_rd_we_i,
  input  logic                      ex_ready_i,
  input  logic                      flush_i,
  input  logic [NumWb-1:0]          wb_valid_i,
  input  logic [NumWb*RegAddrW-1:0] wb_rd_i,
  output logic                      issue_o,
  output logic                      stall_o,
  output logic [NumRegs-1:0]        busy_o,
  output logic [CntW-1:0]           outstanding_o,
  output logic                      err_o
);

  localparam int unsigned WbCntW = $clog2(NumWb + 1);

  logic [NumRegs-1:0] busy_q, busy_d;
  logic [CntW-1:0]    out_q, out_d;
  logic               err_q, err_d;

  reg_addr_t          wb_rd [NumWb];
  logic [NumRegs-1:0] clr_mask;
  logic [NumRegs-1:0] busy_eff;
  logic [WbCntW-1:0]  wb_cnt;
  logic [CntW-1:0]    out_after_wb;
  logic               wb_err;
  logic               full;
  logic               rd_nz;
  logic               hazard;
  logic               sets_rd;

  // Unpack writeback addresses and build the same-cycle clear mask.
  always_comb begin
    clr_mask = '0;
    for (int p = 0; p < NumWb; p++) begin
      wb_rd[p] = wb_rd_i[p*RegAddrW +: RegAddrW];
      if (wb_valid_i[p]) begin
        clr_mask = clr_mask | reg_onehot(wb_rd[p]);
      end
    end
  end

  // Number of valid writeback ports this cycle.
  always_comb begin
    wb_cnt = '0;
    for (int p = 0; p < NumWb; p++) begin
      wb_cnt = wb_cnt + WbCntW'(wb_valid_i[p]);
    end
  end

  // Protocol checks: retiring a free register or x0, or two ports on one register.
  always_comb begin
    wb_err = 1'b0;
    for (int p = 0; p < NumWb; p++) begin
      if (wb_valid_i[p]) begin
        if ((wb_rd[p] == '0) || !busy_q[wb_rd[p]]) begin
          wb_err = 1'b1;
        end
        for (int q = p + 1; q < NumWb; q++) begin
          if (wb_valid_i[q] && (wb_rd[q] == wb_rd[p])) begin
            wb_err = 1'b1;
          end
        end
      end
    end
  end

  // Count after writeback drain; saturates at zero on over-retire.
  always_comb begin
    if (32'(wb_cnt) >= 32'(out_q)) begin
      out_after_wb = '0;
    end else begin
      out_after_wb = out_q - CntW'(wb_cnt);
    end
  end

  always_comb begin
    busy_eff = busy_q & ~clr_mask;
    rd_nz    = (dec_rd_i != '0);
    full     = (32'(out_after_wb) >= MaxOutstanding);
    hazard   = (dec_rs1_use_i & busy_eff[dec_rs1_i])
             | (dec_rs2_use_i & busy_eff[dec_rs2_i])
             | (dec_rd_we_i & busy_eff[dec_rd_i])
             | (dec_rd_we_i & rd_nz & full);
    // Gated by reset so issue/stall drop as soon as reset asserts.
    issue_o  = rst_n_i & dec_valid_i & ~flush_i & ~hazard & ex_ready_i;
    stall_o  = rst_n_i & dec_valid_i & ~flush_i & ~issue_o;
    sets_rd  = issue_o & dec_rd_we_i & rd_nz;
  end

  // Next state: a set on the same register as a clear wins.
  always_comb begin
    busy_d = busy_eff;
    if (sets_rd) begin
      busy_d = busy_d | reg_onehot(dec_rd_i);
    end
    busy_d[0] = 1'b0;
    out_d     = out_after_wb + CntW'(sets_rd);
    err_d     = err_q | wb_err;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_q <= '0;
      out_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      out_q  <= out_d;
      err_q  <= err_d;
    end
  end

  assign busy_o        = busy_q;
  assign outstanding_o = out_q;
  assign err_o         = err_q;

`ifndef NDEBUG
  a_x0_free : assert property (@(posedge clk_i) disable iff (!rst_n_i) busy_q[0] == 1'b0);
  // Only meaningful while no protocol error has corrupted the count.
  a_count : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    err_q || ($countones(busy_q) == 32'(out_q)));
  a_excl : assert property (@(posedge clk_i) disable iff (!rst_n_i) !(issue_o && stall_o));
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic        clk_i;
  logic        rst_n_i;
  logic        dec_valid_i;
  logic [4:0]  dec_rs1_i;
  logic [4:0]  dec_rs2_i;
  logic        dec_rs1_use_i;
  logic        dec_rs2_use_i;
  logic [4:0]  dec_rd_i;
  logic        dec_rd_we_i;
  logic        ex_ready_i;
  logic        flush_i;
  logic [1:0]  wb_valid_i;
  logic [9:0]  wb_rd_i;
  logic        issue_o;
  logic        stall_o;
  logic [31:0] busy_o;
  logic [2:0]  outstanding_o;
  logic        err_o;

  int n_vec;
  int n_err;

  hazard_scoreboard #(.NumWb(2), .MaxOutstanding(4)) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .dec_valid_i   (dec_valid_i),
    .dec_rs1_i     (dec_rs1_i),
    .dec_rs2_i     (dec_rs2_i),
    .dec_rs1_use_i (dec_rs1_use_i),
    .dec_rs2_use_i (dec_rs2_use_i),
    .dec_rd_i      (dec_rd_i),
    .dec_rd_we_i   (dec_rd_we_i),
    .ex_ready_i    (ex_ready_i),
    .flush_i       (flush_i),
    .wb_valid_i    (wb_valid_i),
    .wb_rd_i       (wb_rd_i),
    .issue_o       (issue_o),
    .stall_o       (stall_o),
    .busy_o        (busy_o),
    .outstanding_o (outstanding_o),
    .err_o         (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic idle();
    dec_valid_i   = 1'b0;
    dec_rs1_i     = '0;
    dec_rs2_i     = '0;
    dec_rs1_use_i = 1'b0;
    dec_rs2_use_i = 1'b0;
    dec_rd_i      = '0;
    dec_rd_we_i   = 1'b0;
    ex_ready_i    = 1'b1;
    flush_i       = 1'b0;
    wb_valid_i    = '0;
    wb_rd_i       = '0;
  endtask

  // Drive a decoded instruction at the negedge; caller checks comb outputs after #1.
  task automatic drive_dec(input logic [4:0] rs1, input logic rs1_use, input logic [4:0] rd,
                           input logic rd_we);
    @(negedge clk_i);
    idle();
    dec_valid_i   = 1'b1;
    dec_rs1_i     = rs1;
    dec_rs1_use_i = rs1_use;
    dec_rd_i      = rd;
    dec_rd_we_i   = rd_we;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    idle();
    rst_n_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n_i = 1'b0;
    #12;
    n_vec++;
    if ({issue_o, stall_o, err_o} !== 3'b000) begin
      $display("FAIL reset_ctl: got %b want 000", {issue_o, stall_o, err_o}); n_err++;
    end
    n_vec++;
    if (busy_o !== 32'h0 || outstanding_o !== 3'd0) begin
      $display("FAIL reset_state: got busy=%h out=%0d want 0/0", busy_o, outstanding_o); n_err++;
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  task automatic test_issue();
    drive_dec(5'd0, 1'b0, 5'd5, 1'b1);
    #1;
    n_vec++;
    if ({issue_o, stall_o} !== 2'b10) begin
      $display("FAIL issue_addi: got %b want 10", {issue_o, stall_o}); n_err++;
    end
    @(posedge clk_i); #1;
    n_vec++;
    if (busy_o !== 32'h20 || outstanding_o !== 3'd1) begin
      $display("FAIL issue_state: got busy=%h out=%0d want 20/1", busy_o, outstanding_o); n_err++;
    end
  endtask

  task automatic test_raw();
    for (int c = 0; c < 3; c++) begin
      drive_dec(5'd5, 1'b1, 5'd8, 1'b0);
      #1;
      n_vec++;
      if ({issue_o, stall_o} !== 2'b01) begin
        $display("FAIL raw_stall%0d: got %b want 01", c, {issue_o, stall_o}); n_err++;
      end
    end
    drive_dec(5'd5, 1'b1, 5'd8, 1'b0);
    wb_valid_i = 2'b01;
    wb_rd_i    = {5'd0, 5'd5};
    #1;
    n_vec++;
    if ({issue_o, stall_o} !== 2'b10) begin
      $display("FAIL raw_bypass: got %b want 10", {issue_o, stall_o}); n_err++;
    end
    @(posedge clk_i); #1;
    n_vec++;
    if (busy_o !== 32'h0 || outstanding_o !== 3'd0 || err_o !== 1'b0) begin
      $display("FAIL raw_after: got busy=%h out=%0d err=%b want 0/0/0",
               busy_o, outstanding_o, err_o); n_err++;
    end
  endtask

  task automatic test_capacity();
    for (int r = 1; r <= 4; r++) begin
      drive_dec(5'd0, 1'b0, 5'(r), 1'b1);
      #1;
      n_vec++;
      if (issue_o !== 1'b1) begin
        $display("FAIL cap_fill_x%0d: got %b want 1", r, issue_o); n_err++;
      end
    end
    drive_dec(5'd0, 1'b0, 5'd6, 1'b1);
    #1;
    n_vec++;
    if ({issue_o, stall_o, outstanding_o} !== {2'b01, 3'd4}) begin
      $display("FAIL cap_full: got %b/%0d want 01/4", {issue_o, stall_o}, outstanding_o); n_err++;
    end
    drive_dec(5'd7, 1'b1, 5'd6, 1'b0);
    #1;
    n_vec++;
    if (issue_o !== 1'b1) begin
      $display("FAIL cap_nowrite: got %b want 1", issue_o); n_err++;
    end
    drive_dec(5'd0, 1'b0, 5'd6, 1'b1);
    wb_valid_i = 2'b01;
    wb_rd_i    = {5'd0, 5'd2};
    #1;
    n_vec++;
    if (issue_o !== 1'b1) begin
      $display("FAIL cap_release: got %b want 1", issue_o); n_err++;
    end
    @(posedge clk_i); #1;
    n_vec++;
    if (busy_o !== 32'h5A || outstanding_o !== 3'd4) begin
      $display("FAIL cap_state: got busy=%h out=%0d want 5a/4", busy_o, outstanding_o); n_err++;
    end
  endtask

  task automatic test_dual_wb();
    drive_dec(5'd0, 1'b0, 5'd1, 1'b1);
    wb_valid_i = 2'b11;
    wb_rd_i    = {5'd3, 5'd1};
    #1;
    n_vec++;
    if (issue_o !== 1'b1) begin
      $display("FAIL dual_issue: got %b want 1", issue_o); n_err++;
    end
    @(posedge clk_i); #1;
    n_vec++;
    if (busy_o !== 32'h52 || outstanding_o !== 3'd3 || err_o !== 1'b0) begin
      $display("FAIL dual_state: got busy=%h out=%0d err=%b want 52/3/0",
               busy_o, outstanding_o, err_o); n_err++;
    end
  endtask

  task automatic test_flush();
    drive_dec(5'd4, 1'b1, 5'd9, 1'b1);
    #1;
    n_vec++;
    if ({issue_o, stall_o} !== 2'b01) begin
      $display("FAIL flush_pre: got %b want 01", {issue_o, stall_o}); n_err++;
    end
    flush_i = 1'b1;
    #1;
    n_vec++;
    if ({issue_o, stall_o} !== 2'b00) begin
      $display("FAIL flush_ctl: got %b want 00", {issue_o, stall_o}); n_err++;
    end
    @(posedge clk_i); #1;
    n_vec++;
    if (busy_o !== 32'h52 || outstanding_o !== 3'd3) begin
      $display("FAIL flush_state: got busy=%h out=%0d want 52/3", busy_o, outstanding_o); n_err++;
    end
    // Drain the remaining writes (x1, x4, x6).
    @(negedge clk_i);
    idle();
    wb_valid_i = 2'b11;
    wb_rd_i    = {5'd4, 5'd1};
    @(negedge clk_i);
    wb_valid_i = 2'b01;
    wb_rd_i    = {5'd0, 5'd6};
    @(posedge clk_i); #1;
    n_vec++;
    if (busy_o !== 32'h0 || outstanding_o !== 3'd0 || err_o !== 1'b0) begin
      $display("FAIL drain_state: got busy=%h out=%0d err=%b want 0/0/0",
               busy_o, outstanding_o, err_o); n_err++;
    end
  endtask

  task automatic test_errors();
    @(negedge clk_i);
    idle();
    wb_valid_i = 2'b01;
    wb_rd_i    = {5'd0, 5'd7};
    @(posedge clk_i); #1;
    n_vec++;
    if (err_o !== 1'b1 || outstanding_o !== 3'd0) begin
      $display("FAIL err_free: got err=%b out=%0d want 1/0", err_o, outstanding_o); n_err++;
    end
    @(negedge clk_i);
    idle();
    @(posedge clk_i); #1;
    n_vec++;
    if (err_o !== 1'b1) begin
      $display("FAIL err_sticky: got %b want 1", err_o); n_err++;
    end
    do_reset();
    wb_valid_i = 2'b10;
    wb_rd_i    = {5'd0, 5'd0};
    @(posedge clk_i); #1;
    n_vec++;
    if (err_o !== 1'b1) begin
      $display("FAIL err_x0: got %b want 1", err_o); n_err++;
    end
    do_reset();
    drive_dec(5'd0, 1'b0, 5'd1, 1'b1);
    @(negedge clk_i);
    idle();
    wb_valid_i = 2'b11;
    wb_rd_i    = {5'd1, 5'd1};
    @(posedge clk_i); #1;
    n_vec++;
    if (err_o !== 1'b1 || busy_o !== 32'h0 || outstanding_o !== 3'd0) begin
      $display("FAIL err_dup: got err=%b busy=%h out=%0d want 1/0/0",
               err_o, busy_o, outstanding_o); n_err++;
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    drive_dec(5'd0, 1'b0, 5'd5, 1'b1);
    drive_dec(5'd5, 1'b1, 5'd8, 1'b1);
    #1;
    n_vec++;
    if ({stall_o, busy_o[5]} !== 2'b11) begin
      $display("FAIL mid_pre: got %b want 11", {stall_o, busy_o[5]}); n_err++;
    end
    rst_n_i = 1'b0;
    #1;
    n_vec++;
    if ({issue_o, stall_o, err_o} !== 3'b000 || busy_o !== 32'h0 || outstanding_o !== 3'd0) begin
      $display("FAIL mid_reset: got ctl=%b busy=%h out=%0d want 000/0/0",
               {issue_o, stall_o, err_o}, busy_o, outstanding_o); n_err++;
    end
    @(negedge clk_i);
    idle();
    rst_n_i = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_issue();
    test_raw();
    test_capacity();
    test_dual_wb();
    test_flush();
    test_errors();
    test_reset_mid();
    repeat (2) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
